dir_led_driver: RTL
===================

// Module: dir_led_driver
// PURPOSE
//   Drives a one-hot direction indicator (Pacman joystick/button direction) onto NUM_DIRS LEDs.
//   - Synchronises and debounces the press.
//   - Latches the accepted direction and stretches the LED after release.
//   - Emits a one-cycle pulse per newly accepted direction for the game FSM.
//   - Sits between the button/encoder inputs and the board LEDs plus game control logic.
// PARAMETERS
//   NUM_DIRS         4     number of directions/LEDs, >= 2
//   NUM_W            2     width of num/dir; must equal $clog2(NUM_DIRS)
//   DEBOUNCE_CYCLES  16    consecutive stable cycles required to accept a press, >= 1
//   HOLD_CYCLES      1000  cycles the LED stays lit after release, >= 1
//   BLINK_HALF       250   half-period of the hold-phase blink (BLINK_EN only), >= 1
// PORTS
//   clk        in   1         system clock
//   rst        in   1         synchronous, active-high reset
//   num        in   NUM_W     raw direction code, asynchronous to clk
//   pressed    in   1         raw press level, asynchronous to clk
//   leds       out  NUM_DIRS  registered one-hot indicator; all-zero when idle
//   dir        out  NUM_W     last accepted direction
//   dir_valid  out  1         one-cycle pulse when a new direction is accepted
//   active     out  1         high in ACTIVE and HOLD states
// BEHAVIOUR
//   - Reset (rst=1 at clk edge, any state):
//     state=IDLE, leds=0, dir=0, dir_valid=0, active=0, counters=0, sync flops=0.
//   - Input sync: num and pressed each pass through 2 flops (num_s, pressed_s).
//     press_s = pressed_s & (num_s < NUM_DIRS); out-of-range codes count as released.
//   - IDLE:
//     press_s=1 -> DEBOUNCE; cand<=num_s; cnt<=0.
//   - DEBOUNCE:
//     press_s=0 -> previous stable state: IDLE if entered from IDLE, otherwise HOLD.
//       When returning to HOLD, the hold counter restarts at 0.
//     num_s!=cand -> cand<=num_s; cnt<=0.
//     cnt==DEBOUNCE_CYCLES-1 -> ACTIVE; dir<=cand; leds<=1<<cand; dir_valid=1 for the first ACTIVE cycle.
//     Otherwise cnt<=cnt+1.
//     leds hold their previous value throughout DEBOUNCE.
//   - ACTIVE: leds=1<<dir.
//     press_s=0 -> HOLD; hcnt<=0.
//     press_s=1 and num_s!=dir -> DEBOUNCE; cand<=num_s; cnt<=0.
//   - HOLD: leds keep 1<<dir; hcnt<=hcnt+1.
//     hcnt==HOLD_CYCLES-1 -> IDLE; leds<=0.
//     press_s=1, num_s==dir -> ACTIVE with no dir_valid pulse (re-press of same direction).
//     press_s=1, num_s!=dir -> DEBOUNCE.
//     Press events take priority over hold expiry in the same cycle.
//   - Latency: pressed rising at the pin -> leds/dir_valid high after DEBOUNCE_CYCLES+3 clk edges.
//     Release -> leds low after HOLD_CYCLES+3 edges, provided there is no re-press.
//   - dir_valid fires only when dir changes or when leaving IDLE.
//     Same-direction re-acceptance from DEBOUNCE after ACTIVE/HOLD also fires no pulse.
//   - Counters are sized $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES,BLINK_HALF))+1; they never wrap.
// CONFIGURATION
//   DIR_LED_BLINK_EN defined:
//     - In HOLD, leds alternate 1<<dir (BLINK_HALF cycles) and 0 (BLINK_HALF cycles), starting lit at HOLD entry.
//     - The blink phase counter is reset on every HOLD entry.
//     - ACTIVE stays steady; dir and active are unaffected.
//   Not defined: HOLD is steady 1<<dir and BLINK_HALF is unused.
// TESTING
//   1 rst high 3 cycles mid-ACTIVE with dir=2 -> next cycle leds=0, dir=0, active=0, dir_valid=0.
//   2 DEBOUNCE_CYCLES=4, num=1, pressed 1 held -> leds=4'b0010 and one dir_valid pulse exactly 7 edges after rise.
//   3 pressed glitch 3 cycles (< 4) -> leds stay 0, no dir_valid, state returns IDLE.
//   4 hold num=3, release, HOLD_CYCLES=10 -> leds=4'b1000 for 10 cycles after pressed_s falls, then 0.
//   5 in HOLD, press num=0 for 4 stable cycles -> leds=4'b0001, dir=0, one dir_valid; re-press num=0 again -> no pulse.
//   6 DIR_LED_BLINK_EN, BLINK_HALF=2, HOLD_CYCLES=8, dir=1 -> HOLD leds sequence 2,2,0,0,2,2,0,0 then 0.

Source files
------------

// File: rtl/dir_led_driver.sv
// Debounced one-hot direction indicator: syncs the raw press, latches the accepted direction,
// stretches the LED after release and pulses dir_valid on new directions. Optional hold blink: DIR_LED_BLINK_EN.
module dir_led_driver #(
    parameter int NUM_DIRS        = 4,
    parameter int NUM_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int BLINK_HALF      = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_W-1:0]    num,
    input  logic                pressed,
    output logic [NUM_DIRS-1:0] leds,
    output logic [NUM_W-1:0]    dir,
    output logic                dir_valid,
    output logic                active
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > BLINK_HALF) ? MAX_DH : BLINK_HALF;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, ACTIVE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NUM_W-1:0]     num_m, num_s, cand_q, cand_d, dir_q, dir_d;
    logic                 pressed_m, pressed_s, press_s;
    logic [CNT_W-1:0]     cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [NUM_DIRS-1:0]  leds_q, leds_d;
    logic                 dv_q, dv_d, from_idle_q, from_idle_d;
`ifdef DIR_LED_BLINK_EN
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;
    logic                 dark_q, dark_d;
`endif

    function automatic logic [NUM_DIRS-1:0] onehot(input logic [NUM_W-1:0] d);
        return NUM_DIRS'(1) << d;
    endfunction

    // Codes beyond the last direction are treated as a release.
    assign press_s = pressed_s & ({1'b0, num_s} < (NUM_W+1)'(NUM_DIRS));

    // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        dir_d       = dir_q;
        leds_d      = leds_q;
        dv_d        = 1'b0;
        from_idle_d = from_idle_q;
`ifdef DIR_LED_BLINK_EN
        bcnt_d      = bcnt_q;
        dark_d      = dark_q;
`endif
        case (state_q)
            IDLE: if (press_s) begin
                state_d     = DEBOUNCE;
                cand_d      = num_s;
                cnt_d       = '0;
                from_idle_d = 1'b1;
            end
            DEBOUNCE: begin
                if (!press_s) begin
                    if (from_idle_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hcnt_d  = '0;
                        leds_d  = onehot(dir_q);
                    end
                end else if (num_s != cand_q) begin
                    cand_d = num_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ACTIVE;
                    dir_d   = cand_q;
                    leds_d  = onehot(cand_q);
                    dv_d    = from_idle_q || (cand_q != dir_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                leds_d = onehot(dir_q);
                if (!press_s) begin
                    state_d = HOLD;
                    hcnt_d  = '0;
                end else if (num_s != dir_q) begin
                    state_d     = DEBOUNCE;
                    cand_d      = num_s;
                    cnt_d       = '0;
                    from_idle_d = 1'b0;
                end
            end
            HOLD: begin
                if (press_s && num_s == dir_q) begin
                    state_d = ACTIVE;
                    leds_d  = onehot(dir_q);
                end else if (press_s) begin
                    state_d     = DEBOUNCE;
                    cand_d      = num_s;
                    cnt_d       = '0;
                    from_idle_d = 1'b0;
                end else if (hcnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                    leds_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
`ifdef DIR_LED_BLINK_EN
                    if (bcnt_q == CNT_W'(BLINK_HALF - 1)) begin
                        bcnt_d = '0;
                        dark_d = !dark_q;
                    end else begin
                        bcnt_d = bcnt_q + CNT_W'(1);
                    end
                    leds_d = dark_d ? '0 : onehot(dir_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DIR_LED_BLINK_EN
        // Every HOLD entry restarts the blink in its lit phase.
        if (state_d == HOLD && state_q != HOLD) begin
            bcnt_d = '0;
            dark_d = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_m       <= '0;
            num_s       <= '0;
            pressed_m   <= 1'b0;
            pressed_s   <= 1'b0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            dir_q       <= '0;
            leds_q      <= '0;
            dv_q        <= 1'b0;
            from_idle_q <= 1'b0;
`ifdef DIR_LED_BLINK_EN
            bcnt_q      <= '0;
            dark_q      <= 1'b0;
`endif
        end else begin
            num_m       <= num;
            num_s       <= num_m;
            pressed_m   <= pressed;
            pressed_s   <= pressed_m;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            dir_q       <= dir_d;
            leds_q      <= leds_d;
            dv_q        <= dv_d;
            from_idle_q <= from_idle_d;
`ifdef DIR_LED_BLINK_EN
            bcnt_q      <= bcnt_d;
            dark_q      <= dark_d;
`endif
        end
    end

    assign leds      = leds_q;
    assign dir       = dir_q;
    assign dir_valid = dv_q;
    assign active    = (state_q == ACTIVE) || (state_q == HOLD);

endmodule
